div: RTL and testbench

Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU. The execute stage raises a start request with two operands; the block runs a 32-iteration restoring shift-subtract loop and returns a 64-bit {remainder, quotient} result with a ready flag. Its result goes to HI/LO via the execute stage. The execute stage holds the pipeline stall request while the divider is busy.

---
 rtl/div_pkg.sv | 29 ++
 rtl/div.sv | 126 ++++++++++++
 tb/tb_div.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle integer divider.
// Holds the bus widths, handshake constants, FSM state encoding and the
// two's-complement negate helper used when taking operand magnitudes and
// restoring result signs.
package div_pkg;

  localparam int unsigned RegBus       = 32;
  localparam int unsigned DoubleRegBus = 64;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  // Handshake levels on start_i / ready_o.
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  function automatic logic [RegBus-1:0] negate(input logic [RegBus-1:0] v);
    return ~v + 1'b1;
  endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle 32-bit divider for DIV/DIVU in the execute stage.
// A request accepted in DivFree runs 32 restoring shift-subtract iterations
// on operand magnitudes, then signs are restored and the result is held in
// DivEnd until the execute stage drops start_i.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend, sampled only on acceptance
//   opdata2_i     divisor, sampled only on acceptance
//   start_i       request, held until the result is consumed
//   annul_i       flush; aborts a division (ignored in DivEnd)
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, registered
module div
  import div_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);

  div_state_e        state_q;
  logic [5:0]        cnt_q;
  // {partial remainder, dividend bits / quotient bits, next quotient bit}
  logic [64:0]       work_q;
  logic [RegBus-1:0] divisor_q;
  logic              signed_q;
  logic              quot_neg_q;
  logic              rem_neg_q;

  logic [RegBus-1:0] dividend_abs;
  logic [RegBus-1:0] divisor_abs;
  logic [RegBus:0]   diff;
  logic [RegBus-1:0] quot_fin;
  logic [RegBus-1:0] rem_fin;

  always_comb begin
    dividend_abs = (signed_div_i && opdata1_i[31]) ? negate(opdata1_i) : opdata1_i;
    divisor_abs  = (signed_div_i && opdata2_i[31]) ? negate(opdata2_i) : opdata2_i;
    // diff[32] set means the trial subtraction went negative.
    diff         = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
    quot_fin     = (signed_q && quot_neg_q) ? negate(work_q[31:0]) : work_q[31:0];
    rem_fin      = (signed_q && rem_neg_q) ? negate(work_q[64:33]) : work_q[64:33];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      signed_q   <= 1'b0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      result_o   <= '0;
      ready_o    <= DivResultNotReady;
    end else begin
      unique case (state_q)
        DivFree: begin
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == ZeroWord) begin
              state_q <= DivByZero;
            end else begin
              state_q    <= DivOn;
              cnt_q      <= '0;
              work_q     <= {32'b0, dividend_abs, 1'b0};
              divisor_q  <= divisor_abs;
              signed_q   <= signed_div_i;
              quot_neg_q <= opdata1_i[31] ^ opdata2_i[31];
              rem_neg_q  <= opdata1_i[31];
            end
          end else begin
            ready_o  <= DivResultNotReady;
            result_o <= '0;
          end
        end
        DivByZero: begin
          if (annul_i) begin
            state_q <= DivFree;
          end else begin
            state_q <= DivEnd;
            ready_o <= DivResultReady;
          end
          result_o <= '0;
        end
        DivOn: begin
          if (annul_i) begin
            state_q  <= DivFree;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
          end else if (cnt_q != 6'd32) begin
            if (diff[32]) begin
              work_q <= {work_q[63:0], 1'b0};
            end else begin
              work_q <= {diff[31:0], work_q[31:0], 1'b1};
            end
            cnt_q <= cnt_q + 6'd1;
          end else begin
            state_q  <= DivEnd;
            result_o <= {rem_fin, quot_fin};
            ready_o  <= DivResultReady;
            cnt_q    <= '0;
          end
        end
        DivEnd: begin
          // Only start_i releases the result; a flush here does nothing.
          if (start_i == DivStop) begin
            state_q  <= DivFree;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
          end
        end
        default: state_q <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
module tb_div;
  import div_pkg::*;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int tests;
  int fails;

  div u_dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure acceptance-to-ready latency, hold the result
  // for 5 cycles (with a flush pulse that must be ignored), then release.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res,
                         input int exp_lat);
    int n;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    tick();  // E0
    opdata1_i = 32'hDEAD_BEEF;
    opdata2_i = 32'h0000_0003;
    n = 0;
    while (!ready_o && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_result"}, result_o, exp_res);
    for (int i = 0; i < 5; i++) begin
      annul_i = (i == 2);
      tick();
    end
    annul_i = 1'b0;
    chk({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
    chk({tag, "_hold_result"}, result_o, exp_res);
    start_i = 1'b0;
    tick();
    chk({tag, "_rel_ready"}, 64'(ready_o), 64'd0);
    chk({tag, "_rel_result"}, result_o, 64'd0);
  endtask

  initial begin
    int seen;
    tests = 0;
    fails = 0;
    rst = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    start_i = 1'b0;
    annul_i = 1'b0;
    #12;
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    rst = 1'b1;
    tick();

    run_div("udiv_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    run_div("sdiv_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33);
    run_div("sdiv_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, {32'h0000_0002, 32'hFFFF_FFF2}, 33);
    run_div("div_by_zero", 1'b0, 32'd55, 32'd0, 64'd0, 1);
    run_div("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
    run_div("udiv_big", 1'b0, 32'hFFFF_FFFF, 32'h0001_0000, {32'h0000_FFFF, 32'h0000_FFFF}, 33);

    // Flush at iteration 10: no result ever appears.
    signed_div_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    tick();  // E0
    for (int i = 0; i < 10; i++) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    chk("annul_ready", 64'(ready_o), 64'd0);
    chk("annul_result", result_o, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready_o) seen = 1;
    end
    chk("annul_never_ready", 64'(seen), 64'd0);

    // start and annul together in DivFree are not accepted.
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    annul_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready_o) seen = 1;
    end
    chk("start_annul_rejected", 64'(seen), 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();

    run_div("udiv_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // Asynchronous reset at iteration 20.
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    tick();  // E0
    for (int i = 0; i < 20; i++) tick();
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(ready_o), 64'd0);
    chk("rst_mid_result", result_o, 64'd0);
    start_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Asynchronous reset while a result is held: outputs clear before any edge.
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    for (int i = 0; i < 34; i++) tick();
    chk("pre_rst_ready", 64'(ready_o), 64'd1);
    chk("pre_rst_result", result_o, {32'd0, 32'd3});
    #2 rst = 1'b0;
    #1;
    chk("rst_end_ready", 64'(ready_o), 64'd0);
    chk("rst_end_result", result_o, 64'd0);
    start_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    run_div("after_rst", 1'b1, 32'd100, 32'hFFFF_FFF9, {32'h0000_0002, 32'hFFFF_FFF2}, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
